// File: rtl/wb_master_bridge.sv
// Single-outstanding core request to Wishbone pipelined master bridge.
// Registered response per request; a bus timeout aborts cycles to dead slaves.
module wb_master_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    input  logic                      req_we_i,
    input  logic [DATA_WIDTH/8-1:0]   req_sel_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                      rsp_err_o,

    output logic [ADDR_WIDTH-1:0]     wb_adr_o,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic                      wb_we_o,
    output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
    output logic                      wb_stb_o,
    output logic                      wb_cyc_o,
    output logic                      wb_tagn_o,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_stall_i,
    input  logic                      wb_tagn_i
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] tmo_cnt;
    logic                 expired;
    logic                 ack_taken;

    assign expired     = (tmo_cnt == CNT_WIDTH'(TIMEOUT - 1));
    // An ack only counts once the strobe has been (or is being) accepted.
    assign ack_taken   = wb_ack_i && ((state == WAIT) || (state == REQ && !wb_stall_i));
    assign req_ready_o = (state == IDLE);
    assign wb_tagn_o   = 1'b0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_sel_o    <= '0;
            wb_stb_o    <= 1'b0;
            wb_cyc_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        wb_adr_o <= req_addr_i;
                        wb_dat_o <= req_wdata_i;
                        wb_we_o  <= req_we_i;
                        wb_sel_o <= req_sel_i;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= REQ;
                    end
                end
                REQ, WAIT: begin
                    tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
                    // Ack beats a simultaneous timeout expiry.
                    if (ack_taken) begin
                        rsp_rdata_o <= (wb_we_o || wb_tagn_i) ? '0 : wb_dat_i;
                        rsp_err_o   <= wb_tagn_i;
                        rsp_valid_o <= 1'b1;
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        state       <= RESP;
                    end else if (expired) begin
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        state       <= RESP;
                    end else if (state == REQ && !wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state    <= WAIT;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Scoreboard bench for wb_master_bridge: a driver plays core and slave, a
// monitor checks each response against expectations computed from the plan.
module tb_wb_master_bridge;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i, req_ready_o, req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [3:0]    req_sel_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [DW-1:0] rsp_rdata_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o, wb_dat_i;
    logic          wb_we_o, wb_stb_o, wb_cyc_o, wb_tagn_o;
    logic [3:0]    wb_sel_o;
    logic          wb_ack_i, wb_stall_i, wb_tagn_i;

    wb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_we_i(req_we_i), .req_sel_i(req_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_tagn_o(wb_tagn_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_stall_i(wb_stall_i), .wb_tagn_i(wb_tagn_i)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int unsigned   exp_cyc;
        int unsigned   hold;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One request plus the slave behaviour: s stall cycles, ack d cycles after
    // strobe acceptance (d=0 same cycle); rst_at>0 resets in that bus cycle.
    task automatic run_txn(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic we, input logic [3:0] sel,
                           input int s, input int d, input bit noack, input bit tagn,
                           input logic [DW-1:0] dat, input int hold, input int rst_at);
        int   k;
        int   w;
        bit   tmo;
        exp_t e;
        tmo = noack || (s + 1 + d > int'(TMO));
        k   = tmo ? int'(TMO) : s + 1 + d;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_we_i    = we;
        req_sel_i   = sel;
        req_valid_i = 1'b1;
        w = 0;
        while (!req_ready_o && w < 200) begin
            @(posedge clk_i); #1;
            w++;
        end
        chk("req_ready_wait", req_ready_o, 1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        req_we_i    = 1'(~we);
        req_sel_i   = 4'($urandom);
        if (rst_at == 0) begin
            e.rdata   = (tmo || we || tagn) ? '0 : dat;
            e.err     = tmo || tagn;
            e.exp_cyc = cyc_cnt + k;
            e.hold    = hold;
            sb.push_back(e);
        end
        for (int n = 1; n <= k; n++) begin
            wb_stall_i = (n <= s);
            if (!noack && n == s + 1 + d) begin
                wb_ack_i  = 1'b1;
                wb_tagn_i = tagn;
                wb_dat_i  = dat;
            end else begin
                wb_ack_i  = (n <= s) ? 1'($urandom_range(0, 1)) : 1'b0;
                wb_tagn_i = 1'($urandom_range(0, 1));
                wb_dat_i  = $urandom;
            end
            chk("bus_cyc", wb_cyc_o, 1);
            chk("bus_stb", wb_stb_o, (n <= s + 1));
            chk("bus_fields", {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o}, {addr, wdata, sel, we});
            chk("bus_tagn", wb_tagn_o, 0);
            if (n == rst_at) begin
                wb_ack_i   = 1'b0;
                wb_stall_i = 1'b0;
                rst_i      = 1'b0;
                #1;
                chk("rst_cyc", wb_cyc_o, 0);
                chk("rst_stb", wb_stb_o, 0);
                chk("rst_adr", wb_adr_o, 0);
                chk("rst_req_ready", req_ready_o, 1);
                @(posedge clk_i); #1;
                rst_i = 1'b1;
                repeat (3) begin
                    @(posedge clk_i); #1;
                    chk("rst_no_rsp", rsp_valid_o, 0);
                end
                return;
            end
            @(posedge clk_i); #1;
        end
        chk("end_cyc", wb_cyc_o, 0);
        chk("end_stb", wb_stb_o, 0);
        // Late ack lands while the response is pending and must be ignored.
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'($urandom_range(0, 1));
        wb_tagn_i  = 1'($urandom_range(0, 1));
        wb_dat_i   = $urandom;
        @(posedge clk_i); #1;
        wb_ack_i  = 1'b0;
        wb_tagn_i = 1'b0;
    endtask

    // Response monitor: checks fields every cycle the response is presented,
    // consumes it after the planned number of back-pressure cycles.
    int n_seen = 0;
    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                rsp_ready_i = 1'b0;
                n_seen = 0;
            end else if (rsp_valid_o) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", rsp_valid_o, 0);
                    rsp_ready_i = 1'b1;
                end else begin
                    n_seen++;
                    if (n_seen == 1) chk("rsp_latency", cyc_cnt, sb[0].exp_cyc);
                    chk("rsp_rdata", rsp_rdata_o, sb[0].rdata);
                    chk("rsp_err", rsp_err_o, sb[0].err);
                    chk("req_ready_in_resp", req_ready_o, 0);
                    if (n_seen > int'(sb[0].hold)) begin
                        rsp_ready_i = 1'b1;
                        void'(sb.pop_front());
                        n_seen = 0;
                    end else begin
                        rsp_ready_i = 1'b0;
                    end
                end
            end else begin
                rsp_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_we_i    = 1'b0;
        req_sel_i   = '0;
        wb_dat_i    = '0;
        wb_ack_i    = 1'b0;
        wb_stall_i  = 1'b0;
        wb_tagn_i   = 1'b0;
        #2;
        chk("reset_req_ready", req_ready_o, 1);
        chk("reset_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 0);
        chk("reset_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_tagn_o}, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        run_txn(32'h0000_0040, 32'h0, 1'b0, 4'hF, 0, 1, 1'b0, 1'b0, 32'hDEADBEEF, 0, 0);
        run_txn(32'h0000_0100, 32'h12345678, 1'b1, 4'h3, 3, 1, 1'b0, 1'b0, 32'hA5A5A5A5, 0, 0);
        run_txn(32'h0000_0200, 32'h0, 1'b0, 4'hF, 0, 0, 1'b0, 1'b0, 32'hCAFEF00D, 0, 0);
        run_txn(32'h0000_0300, 32'h0, 1'b0, 4'hF, 0, 0, 1'b1, 1'b0, 32'h11111111, 0, 0);
        run_txn(32'h0000_0400, 32'h0, 1'b0, 4'hF, 0, 2, 1'b0, 1'b1, 32'h22222222, 5, 0);
        run_txn(32'h0000_0500, 32'h0, 1'b0, 4'hF, 0, 20, 1'b1, 1'b0, 32'h0, 0, 3);
        run_txn(32'h0000_0600, 32'h0, 1'b0, 4'h1, 1, 1, 1'b0, 1'b0, 32'h33334444, 0, 0);
        run_txn(32'h0000_0700, 32'h0, 1'b0, 4'hF, 7, 0, 1'b0, 1'b0, 32'h55556666, 0, 0);
        run_txn(32'h0000_0800, 32'h0, 1'b0, 4'hF, 8, 0, 1'b0, 1'b0, 32'h77778888, 0, 0);

        for (int i = 0; i < 60; i++) begin
            int s;
            int d;
            s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 3));
            d = int'($urandom_range(0, 4));
            run_txn($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom),
                    s, d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                    $urandom, int'($urandom_range(0, 2)), 0);
        end

        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk_i); #1;
            w++;
        end
        chk("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Single-outstanding request bridge that converts a core-side valid/ready load/store request into a Wishbone pipelined-mode master cycle. It sits directly upstream of the Wishbone master port and drives `adr/dat_o/we/sel/stb/cyc/tagn_o`. It consumes `dat_i/ack/stall/tagn_i` and returns one registered response per request, with a bus timeout so that a dead slave cannot hang the core.

## Interface
- `ADDR_WIDTH`, 32, Wishbone address width
- `DATA_WIDTH`, 32, data width; multiple of 8; `sel` is `DATA_WIDTH/8`
- `TIMEOUT`, 255, maximum cycles with `cyc` high before abort; ≥2
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  request accepted when `req_valid_i && req_ready_o`
- `req_addr_i`  in  ADDR_WIDTH  address
- `req_wdata_i`  in  DATA_WIDTH  write data
- `req_we_i`  in  1  1 = write
- `req_sel_i`  in  DATA_WIDTH/8  byte enables
- `rsp_valid_o`  out  1  response present
- `rsp_ready_i`  in  1  response consumed when `rsp_valid_o && rsp_ready_i`
- `rsp_rdata_o`  out  DATA_WIDTH  read data; 0 for writes and errors
- `rsp_err_o`  out  1  timeout, or `tagn_i` set with `ack`
- `wb_adr_o`, `wb_dat_o`, `wb_we_o`, `wb_sel_o`, `wb_stb_o`, `wb_cyc_o`, `wb_tagn_o`  out  per bus  Wishbone master outputs
- `wb_dat_i`, `wb_ack_i`, `wb_stall_i`, `wb_tagn_i`  in  per bus  Wishbone master inputs

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready_o = 1`.
  - On handshake, latch addr/wdata/we/sel into the bus output registers, clear the timeout counter, and go to REQ.
- REQ:
  - `cyc = stb = 1`.
  - When `stall = 0`, the strobe is accepted.
    - If `ack` is also set in that cycle, go to RESP.
    - Otherwise go to WAIT with `stb = 0`.
- WAIT:
  - `cyc = 1`, `stb = 0`.
  - On `ack`, go to RESP.
- Response capture (on `ack`):
  - `rsp_rdata_o` = `wb_dat_i` for reads, 0 for writes.
  - `rsp_err_o` = `wb_tagn_i`.
  - Drop `cyc`.
- Timeout:
  - The counter increments every cycle in REQ/WAIT.
  - When it reaches `TIMEOUT - 1` without `ack`, drop `cyc/stb` and go to RESP with `rsp_err_o = 1` and `rsp_rdata_o = 0`.
  - If `ack` arrives in the same cycle as expiry, `ack` wins.
- RESP:
  - `rsp_valid_o = 1`; response fields are held stable.
  - On `rsp_ready_i`, go to IDLE.
  - `req_ready_o` stays 0 until IDLE. No back-to-back overlap.
- `ack` while in IDLE or RESP, or while `stall = 1` in REQ: ignored.
- `wb_tagn_o` is driven 0 at all times.
- Bus outputs (`adr/dat/we/sel`) hold their value from acceptance until the next request; they are not cleared at the end of the cycle.

## Timing
- Reset values (asynchronous, while `rst_i = 0`):
  - state IDLE
  - `req_ready_o = 1`, `rsp_valid_o = 0`, `rsp_err_o = 0`, `rsp_rdata_o = 0`
  - `wb_cyc_o = wb_stb_o = wb_we_o = 0`, `wb_adr_o = 0`, `wb_dat_o = 0`, `wb_sel_o = 0`, `wb_tagn_o = 0`
  - timeout counter 0
- Reset mid-transaction discards the transaction. `cyc` drops asynchronously and no response is issued.
- All outputs are registered, with no combinational path from inputs to outputs, except `req_ready_o`, which is decoded from the state register only.
- Latency, handshake at T0:
  - `cyc/stb` high at T1.
  - With no stall and `ack` at T1 (same-cycle slave), `rsp_valid_o` is high at T2.
  - With `ack` at T2, `rsp_valid_o` is high at T3.
- Each stall cycle adds 1 cycle.
- Minimum request-to-request period is 3 cycles when `rsp_ready_i` is tied 1.
- Timeout: `rsp_valid_o` with `rsp_err_o` is asserted `TIMEOUT + 1` cycles after the handshake.

## Test plan
- Read, slave not stalling, `ack` 1 cycle after `stb` with `dat_i = 0xDEADBEEF` -> `cyc` high for exactly 2 cycles; `rsp_valid_o` at T3; `rsp_rdata_o = 0xDEADBEEF`; `rsp_err_o = 0`.
- Write to `0x100`, data `0x12345678`, sel `0x3`, `stall` high for 3 cycles -> `stb` high for 4 cycles with stable `adr/dat/sel/we = 1`; `rsp_rdata_o = 0`; `rsp_err_o = 0`.
- Same-cycle `ack` with `stall = 0` at T1 -> `stb` high 1 cycle; `rsp_valid_o` at T2; no WAIT state.
- `TIMEOUT = 8`, slave never acks -> `cyc` drops after 8 bus cycles; `rsp_err_o = 1`; `rsp_rdata_o = 0`; a late `ack` is ignored.
- `ack` with `tagn_i = 1` -> `rsp_err_o = 1`; `rsp_valid_o` held with `rsp_ready_i = 0` for 5 cycles, fields stable, `req_ready_o = 0` throughout.
- `rst_i` pulled low during WAIT -> `cyc/stb` low immediately; no `rsp_valid_o` after release; next request completes normally.
